// File: rtl/coin_change_dispenser.sv
// rtl/coin_change_dispenser.sv - refund dispenser paying 10- and 5-coins from a tracked inventory
module coin_change_dispenser (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [3:0] amount,
  input  logic       load,
  input  logic [3:0] load_n5,
  input  logic [3:0] load_n10,
  input  logic       coin_ack,
  output logic [1:0] coin_out,
  output logic       coin_valid,
  output logic       busy,
  output logic       done,
  output logic       short_err,
  output logic [3:0] inv5,
  output logic [3:0] inv10
);

  typedef enum logic [1:0] {IDLE, PLAN, EMIT, FINISH} state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  state_t     state, state_d;
  logic [3:0] rem, rem_d;
  logic [3:0] p10, p10_d;
  logic [3:0] p5, p5_d;
  logic       planned, planned_d;
  logic [3:0] inv5_d, inv10_d;
  logic [1:0] coin_out_d;
  logic       coin_valid_d, busy_d, done_d, short_err_d;

  logic [3:0] half;
  logic [3:0] p10_calc;
  logic [3:0] p5_calc;
  logic [3:0] p10_left;
  logic [3:0] p5_left;

  // Plan arithmetic: as many 10-coins as stock and amount allow, remainder in 5-coins
  always_comb begin
    half     = {1'b0, rem[3:1]};
    p10_calc = (inv10 < half) ? inv10 : half;
    p5_calc  = rem - {p10_calc[2:0], 1'b0};
    p10_left = p10 - 4'd1;
    p5_left  = p5 - 4'd1;
  end

  // Next-state and next-output logic; PLAN spends one cycle building the plan, one deciding
  always_comb begin
    state_d      = state;
    rem_d        = rem;
    p10_d        = p10;
    p5_d         = p5;
    planned_d    = planned;
    inv5_d       = inv5;
    inv10_d      = inv10;
    coin_out_d   = coin_out;
    coin_valid_d = coin_valid;
    busy_d       = busy;
    done_d       = 1'b0;
    short_err_d  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          inv5_d  = load_n5;
          inv10_d = load_n10;
        end else if (req) begin
          rem_d     = amount;
          planned_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = PLAN;
        end
      end
      PLAN: begin
        if (!planned) begin
          p10_d     = p10_calc;
          p5_d      = p5_calc;
          planned_d = 1'b1;
        end else if (p5 > inv5) begin
          short_err_d = 1'b1;
          p10_d       = 4'd0;
          p5_d        = 4'd0;
          rem_d       = 4'd0;
          planned_d   = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else if (p10 == 4'd0 && p5 == 4'd0) begin
          planned_d = 1'b0;
          state_d   = FINISH;
        end else begin
          planned_d    = 1'b0;
          coin_valid_d = 1'b1;
          coin_out_d   = (p10 != 4'd0) ? COIN_10 : COIN_5;
          state_d      = EMIT;
        end
      end
      EMIT: begin
        if (coin_ack) begin
          if (coin_out == COIN_10) begin
            p10_d   = p10_left;
            inv10_d = inv10 - 4'd1;
            if (p10_left != 4'd0) begin
              coin_out_d = COIN_10;
            end else if (p5 != 4'd0) begin
              coin_out_d = COIN_5;
            end else begin
              coin_out_d   = COIN_NONE;
              coin_valid_d = 1'b0;
              state_d      = FINISH;
            end
          end else begin
            p5_d   = p5_left;
            inv5_d = inv5 - 4'd1;
            if (p5_left == 4'd0) begin
              coin_out_d   = COIN_NONE;
              coin_valid_d = 1'b0;
              state_d      = FINISH;
            end
          end
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        rem_d   = 4'd0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rem        <= 4'd0;
      p10        <= 4'd0;
      p5         <= 4'd0;
      planned    <= 1'b0;
      inv5       <= 4'd0;
      inv10      <= 4'd0;
      coin_out   <= COIN_NONE;
      coin_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      short_err  <= 1'b0;
    end else begin
      state      <= state_d;
      rem        <= rem_d;
      p10        <= p10_d;
      p5         <= p5_d;
      planned    <= planned_d;
      inv5       <= inv5_d;
      inv10      <= inv10_d;
      coin_out   <= coin_out_d;
      coin_valid <= coin_valid_d;
      busy       <= busy_d;
      done       <= done_d;
      short_err  <= short_err_d;
    end
  end

endmodule
